// File: rtl/ps2_types.sv
// Shared PS/2 types for the host transmit and receive paths.
//   t_ps2_pins      : open-drain pin pair (clk, data); 1 = float high, 0 = pull low
//   t_ps2_tx_status : completion status reported with tx_done
//   t_ps2_tx_state  : host transmit state machine encoding
//   PS2_*           : default tick counts for 3us ticks
//   ps2_tx_frame    : data bits, odd parity and stop bit in shift order
package ps2_types;

    typedef struct packed {
        logic clk;
        logic data;
    } t_ps2_pins;

    typedef enum logic [1:0] {
        TX_ACKED   = 2'd0,
        TX_NACK    = 2'd1,
        TX_TIMEOUT = 2'd2
    } t_ps2_tx_status;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SHIFT,
        WAIT_IDLE
    } t_ps2_tx_state;

    localparam int PS2_INHIBIT_TICKS      = 40;
    localparam int PS2_FIRST_EDGE_TIMEOUT = 5000;
    localparam int PS2_EDGE_TIMEOUT       = 100;

    // Bits 0..7 are the data (LSB first), bit 8 odd parity, bit 9 the stop bit.
    function automatic logic [9:0] ps2_tx_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_tick_divider.sv
// 3us tick generator shared by the PS/2 host transmit and receive paths.
//   clk, reset : system clock, asynchronous active-high reset
//   divider    : system clocks per tick; 0 stops the ticks
//   enable     : counter runs only while high, otherwise held at 0
//   tick       : one-cycle pulse every divider clocks
module ps2_tick_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] divider,
    input  logic        enable,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic        run;

    assign run = enable && (divider != 16'd0);
    // >= rather than == so that shrinking divider mid-count cannot make the
    // counter run past the terminal value and wrap.
    assign tick = run && (cnt_q >= divider - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else if (!run || tick) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: accepts one byte over valid/ready, runs the
// request-to-send sequence (inhibit, request, shift on device clock, ack check)
// and reports a completion status.
//   clk, reset            : system clock, asynchronous active-high reset
//   divider               : system clocks per 3us tick; 0 disables the block
//   ps2_in__clk/data      : raw pin values
//   tx_valid/tx_data      : command byte offer
//   tx_ready              : idle and able to accept a byte
//   tx_active             : transfer in progress (receiver ignores pins)
//   tx_done/tx_status     : one-cycle completion pulse, 0 ack / 1 nack / 2 timeout
//   ps2_out__clk/data     : open-drain drive, 1 = float, 0 = pull low
module ps2_host_tx
    import ps2_types::*;
#(
    parameter int INHIBIT_TICKS      = PS2_INHIBIT_TICKS,
    parameter int FIRST_EDGE_TIMEOUT = PS2_FIRST_EDGE_TIMEOUT,
    parameter int EDGE_TIMEOUT       = PS2_EDGE_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] divider,
    input  logic        ps2_in__clk,
    input  logic        ps2_in__data,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        tx_active,
    output logic        tx_done,
    output logic [1:0]  tx_status,
    output logic        ps2_out__clk,
    output logic        ps2_out__data
);

    localparam logic [15:0] INHIBIT_LAST = 16'(INHIBIT_TICKS - 1);
    localparam logic [15:0] FIRST_LOAD   = 16'(FIRST_EDGE_TIMEOUT);
    localparam logic [15:0] EDGE_LOAD    = 16'(EDGE_TIMEOUT);

    t_ps2_tx_state  state_q, state_d;
    t_ps2_pins      pins_p0, pins_p1, ps2_out;
    t_ps2_tx_status held_status;
    logic           clk_prev_p2;
    logic           fall, tick, tick_en, accept, expire, timeout_hit;
    logic [15:0]    inhibit_cnt, timeout_cnt;
    logic [3:0]     edge_cnt;
    logic           data_bit;
    logic [9:0]     frame;

    ps2_tick_divider u_tick (
        .clk     (clk),
        .reset   (reset),
        .divider (divider),
        .enable  (tick_en),
        .tick    (tick)
    );

    assign tick_en   = (state_q != IDLE);
    // Gated with reset so the block does not look ready while held in reset.
    assign tx_ready  = (state_q == IDLE) && (divider != 16'd0) && !reset;
    assign tx_active = (state_q != IDLE);
    assign accept    = tx_valid && tx_ready;
    assign expire    = tick && (timeout_cnt == 16'd1);

    // Stage p0/p1: two-flop pin synchroniser; p2: previous clk for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pins_p0     <= '1;
            pins_p1     <= '1;
            clk_prev_p2 <= 1'b1;
        end else begin
            pins_p0     <= {ps2_in__clk, ps2_in__data};
            pins_p1     <= pins_p0;
            clk_prev_p2 <= pins_p1.clk;
        end
    end

    assign fall = clk_prev_p2 && !pins_p1.clk;

    // Frame is pure data, captured only on acceptance.
    always_ff @(posedge clk) begin
        if (accept) frame <= ps2_tx_frame(tx_data);
    end

    always_comb begin
        state_d     = state_q;
        tx_done     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = INHIBIT;
            INHIBIT: if (tick && inhibit_cnt == INHIBIT_LAST) state_d = REQUEST;
            REQUEST: if (tick) state_d = SHIFT;
            SHIFT: begin
                // A falling edge takes priority over an expiring timeout.
                if (fall) begin
                    if (edge_cnt == 4'd10) state_d = WAIT_IDLE;
                end else if (expire) begin
                    state_d     = IDLE;
                    tx_done     = 1'b1;
                    timeout_hit = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (pins_p1.clk && pins_p1.data) begin
                    state_d = IDLE;
                    tx_done = 1'b1;
                end else if (expire) begin
                    state_d     = IDLE;
                    tx_done     = 1'b1;
                    timeout_hit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_status = !tx_done    ? 2'(TX_ACKED)   :
                       timeout_hit ? 2'(TX_TIMEOUT) : 2'(held_status);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            inhibit_cnt <= 16'd0;
            timeout_cnt <= 16'd0;
            edge_cnt    <= 4'd0;
            data_bit    <= 1'b1;
            held_status <= TX_ACKED;
        end else begin
            state_q <= state_d;
            case (state_q)
                INHIBIT: begin
                    if (tick) inhibit_cnt <= (inhibit_cnt == INHIBIT_LAST) ? 16'd0 : inhibit_cnt + 16'd1;
                end
                REQUEST: begin
                    if (tick) begin
                        edge_cnt    <= 4'd0;
                        timeout_cnt <= FIRST_LOAD;
                        data_bit    <= 1'b0;   // start bit
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        edge_cnt    <= edge_cnt + 4'd1;
                        timeout_cnt <= EDGE_LOAD;
                        // Edges 1..10 drive frame[edge-1]; edge 11 samples the ack.
                        if (edge_cnt < 4'd10) data_bit <= frame[edge_cnt];
                        else held_status <= pins_p1.data ? TX_NACK : TX_ACKED;
                    end else if (tick) begin
                        timeout_cnt <= timeout_cnt - 16'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (tick && timeout_cnt != 16'd0) timeout_cnt <= timeout_cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ps2_out = '1;
        case (state_q)
            INHIBIT: ps2_out.clk = 1'b0;
            REQUEST: begin
                ps2_out.clk  = 1'b0;
                ps2_out.data = 1'b0;
            end
            SHIFT:   ps2_out.data = data_bit;
            default: ;
        endcase
    end

    assign ps2_out__clk  = ps2_out.clk;
    assign ps2_out__data = ps2_out.data;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] divider;
    logic        dev_clk, dev_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready, tx_active, tx_done;
    logic [1:0]  tx_status;
    logic        ps2_out__clk, ps2_out__data;
    logic        ps2_in__clk, ps2_in__data;

    int vectors    = 0;
    int miscompares = 0;

    // Open-drain bus: either side can pull a line low.
    assign ps2_in__clk  = ps2_out__clk  & dev_clk;
    assign ps2_in__data = ps2_out__data & dev_data;

    ps2_host_tx dut (
        .clk           (clk),
        .reset         (reset),
        .divider       (divider),
        .ps2_in__clk   (ps2_in__clk),
        .ps2_in__data  (ps2_in__data),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .tx_active     (tx_active),
        .tx_done       (tx_done),
        .tx_status     (tx_status),
        .ps2_out__clk  (ps2_out__clk),
        .ps2_out__data (ps2_out__data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n, output logic got);
        n = 0;
        while (tx_done !== 1'b1 && n < budget) begin
            n++;
            @(negedge clk);
        end
        got = (tx_done === 1'b1);
    endtask

    // Device model: waits for the request, generates n_edges clock pulses,
    // reads data on rising edges 1..10 and drives ack before edge 11.
    task automatic run_device(input int half, input int n_edges, input logic ack,
                              output logic [9:0] seen, output logic req_ok);
        int n;
        seen   = '0;
        req_ok = 1'b0;
        n      = 0;
        while (!(ps2_out__clk === 1'b1 && ps2_out__data === 1'b0) && n < 20000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20000) return;
        req_ok = 1'b1;
        repeat (half) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            dev_clk = 1'b0;
            repeat (half) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) seen[k-1] = ps2_in__data;
            if (k == 10) dev_data = ack;
            if (k < 11) repeat (half) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; divider = 16'd150; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (ps2_out__clk !== 1'b1) begin miscompares++; $display("FAIL reset_out_clk: got %b want 1", ps2_out__clk); end
        vectors++; if (ps2_out__data !== 1'b1) begin miscompares++; $display("FAIL reset_out_data: got %b want 1", ps2_out__data); end
        vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
        vectors++; if (tx_active !== 1'b0) begin miscompares++; $display("FAIL reset_tx_active: got %b want 0", tx_active); end
        vectors++; if (tx_done !== 1'b0) begin miscompares++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
        vectors++; if (tx_status !== 2'd0) begin miscompares++; $display("FAIL reset_tx_status: got %0d want 0", tx_status); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %b want 1", tx_ready); end
    endtask

    task automatic test_acked;
        int n; logic got, ok; logic [9:0] seen;
        divider = 16'd150;
        start_tx(8'hF4);
        vectors++; if (tx_active !== 1'b1 || tx_ready !== 1'b0) begin miscompares++; $display("FAIL ack_busy: got active=%b ready=%b want 1 0", tx_active, tx_ready); end
        n = 0;
        while (ps2_out__clk === 1'b0 && ps2_out__data === 1'b1 && n < 10000) begin n++; @(negedge clk); end
        vectors++; if (n !== 6000) begin miscompares++; $display("FAIL ack_inhibit_cycles: got %0d want 6000", n); end
        n = 0;
        while (ps2_out__clk === 1'b0 && ps2_out__data === 1'b0 && n < 10000) begin n++; @(negedge clk); end
        vectors++; if (n !== 150) begin miscompares++; $display("FAIL ack_request_cycles: got %0d want 150", n); end
        run_device(30, 11, 1'b0, seen, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL ack_request_seen: got %b want 1", ok); end
        vectors++; if (seen !== 10'b1_0_1111_0100) begin miscompares++; $display("FAIL ack_bits: got %b want 1011110100", seen); end
        wait_done(200, n, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL ack_done: got %b want 1", got); end
        vectors++; if (tx_status !== 2'd0) begin miscompares++; $display("FAIL ack_status: got %0d want 0", tx_status); end
        @(negedge clk);
        vectors++; if (tx_ready !== 1'b1 || tx_active !== 1'b0) begin miscompares++; $display("FAIL ack_idle: got ready=%b active=%b want 1 0", tx_ready, tx_active); end
    endtask

    task automatic test_nack;
        int n; logic got, ok; logic [9:0] seen;
        divider = 16'd4;
        start_tx(8'hFF);
        run_device(30, 11, 1'b1, seen, ok);
        vectors++; if (seen !== 10'b11_1111_1111) begin miscompares++; $display("FAIL nack_bits: got %b want 1111111111", seen); end
        wait_done(200, n, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL nack_done: got %b want 1", got); end
        vectors++; if (tx_status !== 2'd1) begin miscompares++; $display("FAIL nack_status: got %0d want 1", tx_status); end
        @(negedge clk);
    endtask

    task automatic test_no_device;
        int n; logic got;
        divider = 16'd2;
        start_tx(8'hED);
        n = 0;
        while (ps2_out__clk !== 1'b1 && n < 1000) begin n++; @(negedge clk); end
        vectors++; if (ps2_out__data !== 1'b0) begin miscompares++; $display("FAIL nodev_start_bit: got %b want 0", ps2_out__data); end
        // Counted from the first SHIFT cycle: 5000 ticks x 2 clocks minus that cycle.
        wait_done(20000, n, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL nodev_done: got %b want 1", got); end
        vectors++; if (n !== 9999) begin miscompares++; $display("FAIL nodev_latency: got %0d want 9999", n); end
        vectors++; if (tx_status !== 2'd2) begin miscompares++; $display("FAIL nodev_status: got %0d want 2", tx_status); end
        @(negedge clk);
        vectors++; if (ps2_out__clk !== 1'b1 || ps2_out__data !== 1'b1 || tx_active !== 1'b0) begin miscompares++; $display("FAIL nodev_release: got clk=%b data=%b active=%b want 1 1 0", ps2_out__clk, ps2_out__data, tx_active); end
    endtask

    task automatic test_stall;
        int n; logic got, ok; logic [9:0] seen;
        divider = 16'd4;
        start_tx(8'hA5);
        run_device(30, 4, 1'b0, seen, ok);
        vectors++; if (seen[3:0] !== 4'b0101) begin miscompares++; $display("FAIL stall_bits: got %b want 0101", seen[3:0]); end
        // Edge 4 is seen 2 cycles after the pin falls, reload 1 later, then 100
        // ticks of 4 clocks; the device returned 60 cycles after the fall.
        wait_done(1000, n, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL stall_done: got %b want 1", got); end
        vectors++; if (n < 339 || n > 342) begin miscompares++; $display("FAIL stall_latency: got %0d want 339..342", n); end
        vectors++; if (tx_status !== 2'd2) begin miscompares++; $display("FAIL stall_status: got %0d want 2", tx_status); end
        @(negedge clk);
        vectors++; if (ps2_out__clk !== 1'b1 || ps2_out__data !== 1'b1 || tx_active !== 1'b0) begin miscompares++; $display("FAIL stall_release: got clk=%b data=%b active=%b want 1 1 0", ps2_out__clk, ps2_out__data, tx_active); end
    endtask

    task automatic test_reset_mid;
        int pulses; logic ok; logic [9:0] seen;
        divider = 16'd4;
        start_tx(8'h1C);
        run_device(30, 6, 1'b0, seen, ok);
        vectors++; if (seen[5:0] !== 6'b011100) begin miscompares++; $display("FAIL rmid_bits: got %b want 011100", seen[5:0]); end
        vectors++; if (ps2_out__clk !== 1'b1 || ps2_out__data !== 1'b0) begin miscompares++; $display("FAIL rmid_pre: got clk=%b data=%b want 1 0", ps2_out__clk, ps2_out__data); end
        reset = 1'b1;
        #1;
        vectors++; if (ps2_out__clk !== 1'b1 || ps2_out__data !== 1'b1) begin miscompares++; $display("FAIL rmid_release: got clk=%b data=%b want 1 1", ps2_out__clk, ps2_out__data); end
        vectors++; if (tx_active !== 1'b0 || tx_done !== 1'b0) begin miscompares++; $display("FAIL rmid_state: got active=%b done=%b want 0 0", tx_active, tx_done); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got %b want 1", tx_ready); end
        pulses = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx_done === 1'b1) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL rmid_no_done: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_back_to_back;
        int n; logic got, ok; logic [9:0] seen;
        divider  = 16'd0;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        repeat (20) @(negedge clk);
        vectors++; if (tx_ready !== 1'b0 || tx_active !== 1'b0) begin miscompares++; $display("FAIL b2b_disabled: got ready=%b active=%b want 0 0", tx_ready, tx_active); end
        divider = 16'd4;
        @(negedge clk);
        vectors++; if (tx_active !== 1'b1) begin miscompares++; $display("FAIL b2b_first_accept: got %b want 1", tx_active); end
        run_device(30, 11, 1'b0, seen, ok);
        vectors++; if (seen !== 10'b11_0101_0101) begin miscompares++; $display("FAIL b2b_bits1: got %b want 1101010101", seen); end
        wait_done(200, n, got);
        vectors++; if (got !== 1'b1 || tx_status !== 2'd0) begin miscompares++; $display("FAIL b2b_done1: got done=%b status=%0d want 1 0", got, tx_status); end
        tx_data = 8'hAA;
        @(negedge clk);
        vectors++; if (tx_ready !== 1'b1 || tx_active !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: got ready=%b active=%b want 1 0", tx_ready, tx_active); end
        @(negedge clk);
        vectors++; if (tx_active !== 1'b1 || tx_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_second_accept: got active=%b ready=%b want 1 0", tx_active, tx_ready); end
        tx_valid = 1'b0;
        run_device(30, 11, 1'b1, seen, ok);
        vectors++; if (seen !== 10'b11_1010_1010) begin miscompares++; $display("FAIL b2b_bits2: got %b want 1110101010", seen); end
        wait_done(200, n, got);
        vectors++; if (got !== 1'b1 || tx_status !== 2'd1) begin miscompares++; $display("FAIL b2b_done2: got done=%b status=%0d want 1 1", got, tx_status); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_acked();
        test_nack();
        test_no_device();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
